// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execute stage: opcode map (also used by the
// ALU control decoder), FSM state encoding and the default datapath width.
package alu_exec_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0110;
    localparam logic [3:0] ALU_EQU = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic isShift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_comb.sv
// Single-cycle ALU operations; unknown codes (shifts included) yield zero
// here because shifts are produced by the iterative path in the top level.
module alu_comb_core
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD: result = op_a + op_b;
            ALU_SUB: result = op_a - op_b;
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_XOR: result = op_a ^ op_b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_EQU: result = {{(XLEN-1){1'b0}}, (op_a == op_b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute stage: single-cycle ops via alu_comb_core, shifts one
// bit per cycle, result/zero presented through a valid/ready output.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [1:0]         state_q, state_d;
    logic [XLEN-1:0]    accum_q, accum_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         shiftOp_q, shiftOp_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               zero_q, zero_d;

    logic [XLEN-1:0]    coreResult;
    logic [XLEN-1:0]    shifted;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;

    alu_comb_core #(.XLEN(XLEN)) u_core (
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .result      (coreResult)
    );

    // Draining DONE and accepting a new op can happen on the same edge.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign shamt     = op_b[SHAMT_W-1:0];
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    always_comb begin
        shifted = accum_q;
        case (shiftOp_q)
            ALU_SLL: shifted = accum_q << 1;
            ALU_SRL: shifted = accum_q >> 1;
            default: shifted = {accum_q[XLEN-1], accum_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        accum_d   = accum_q;
        cnt_d     = cnt_q;
        shiftOp_d = shiftOp_q;
        result_d  = result_q;
        zero_d    = zero_q;
        case (state_q)
            ST_SHIFT: begin
                accum_d = shifted;
                cnt_d   = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                    state_d  = ST_DONE;
                end
            end
            default: begin
                if (accept) begin
                    if (isShift(alu_control)) begin
                        accum_d   = op_a;
                        cnt_d     = shamt;
                        shiftOp_d = alu_control;
                        if (shamt == '0) begin
                            result_d = op_a;
                            zero_d   = (op_a == '0);
                            state_d  = ST_DONE;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        result_d = coreResult;
                        zero_d   = (coreResult == '0);
                        state_d  = ST_DONE;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            accum_q   <= '0;
            cnt_q     <= '0;
            shiftOp_q <= ALU_SLL;
            result_q  <= '0;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            accum_q   <= accum_d;
            cnt_q     <= cnt_d;
            shiftOp_q <= shiftOp_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, multi-cycle
// corner sequences, and random ops against an arithmetic reference model.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expResult;
        logic        expZero;
        int          expLat;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] expQ[$];

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference behaviour written directly from the opcode rules.
    function automatic logic [31:0] refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [31:0] r;
        sh = int'(b[4:0]);
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd3:    r = a & b;
            4'd4:    r = a | b;
            4'd5:    r = a ^ b;
            4'd6:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:    r = (a == b) ? 32'd1 : 32'd0;
            4'd8:    r = a << sh;
            4'd9:    r = a >> sh;
            4'd10:   r = $signed(a) >>> sh;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int refLat(input logic [3:0] op, input logic [31:0] b);
        return (op >= 4'd8 && op <= 4'd10) ? 1 + int'(b[4:0]) : 1;
    endfunction

    // Issues one op, then waits (bounded) for its result.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic z, output int lat, output int busyReady);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        checkOutput("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_valid    = 1'b1;
        alu_control = op;
        op_a        = a;
        op_b        = b;
        step();
        in_valid    = 1'b0;
        alu_control = 4'($urandom);
        op_a        = $urandom;
        op_b        = $urandom;
        lat         = 1;
        busyReady   = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busyReady++;
            step();
            lat++;
        end
        res = result;
        z   = zero;
    endtask

    initial begin
        logic [31:0] res;
        logic        z;
        int          lat;
        int          busy;
        int          stray;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expd;

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        alu_control = 4'd0;
        op_a        = '0;
        op_b        = '0;
        step();
        step();
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_zero", {31'b0, zero}, 32'd1);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        step();

        // Reset in the middle of a long shift.
        in_valid    = 1'b1;
        alu_control = ALU_SLL;
        op_a        = 32'd1;
        op_b        = 32'd20;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        checkOutput("midshift_in_ready", {31'b0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midshift_rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midshift_rst_result", result, 32'd0);
        checkOutput("midshift_rst_zero", {31'b0, zero}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midshift_release_in_ready", {31'b0, in_ready}, 32'd1);
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid) stray++;
        end
        checkOutput("midshift_no_stale_result", 32'(stray), 32'd0);

        // Directed vectors: op, a, b, result, zero, latency.
        vecs.push_back('{ALU_ADD, 32'hFFFF_FFFF, 32'h1,          32'h0,          1'b1, 1});
        vecs.push_back('{ALU_SUB, 32'h5,         32'h7,          32'hFFFF_FFFE,  1'b0, 1});
        vecs.push_back('{ALU_SLT, 32'hFFFF_FFFF, 32'h1,          32'h1,          1'b0, 1});
        vecs.push_back('{ALU_SLT, 32'h1,         32'hFFFF_FFFF,  32'h0,          1'b1, 1});
        vecs.push_back('{ALU_EQU, 32'h1234,      32'h1234,       32'h1,          1'b0, 1});
        vecs.push_back('{ALU_EQU, 32'h1234,      32'h1235,       32'h0,          1'b1, 1});
        vecs.push_back('{4'hF,    32'h55,        32'h66,         32'h0,          1'b1, 1});
        vecs.push_back('{4'h2,    32'h5,         32'h5,          32'h0,          1'b1, 1});
        vecs.push_back('{ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000,  1'b0, 1});
        vecs.push_back('{ALU_OR,  32'h0F,        32'hF0,         32'hFF,         1'b0, 1});
        vecs.push_back('{ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000,  32'h5555_5555,  1'b0, 1});
        vecs.push_back('{ALU_SRA, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF,  1'b0, 32});
        vecs.push_back('{ALU_SLL, 32'hABCD,      32'd0,          32'hABCD,       1'b0, 1});
        vecs.push_back('{ALU_SLL, 32'h1,         32'h24,         32'h10,         1'b0, 5});
        vecs.push_back('{ALU_SRL, 32'h8000_0000, 32'd31,         32'h1,          1'b0, 32});
        vecs.push_back('{ALU_SRA, 32'h7FFF_FFF0, 32'd4,          32'h07FF_FFFF,  1'b0, 5});
        vecs.push_back('{ALU_SLL, 32'h8000_0001, 32'd1,          32'h2,          1'b0, 2});
        vecs.push_back('{ALU_SRL, 32'h1,         32'd1,          32'h0,          1'b1, 2});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat, busy);
            checkOutput($sformatf("vec%0d_result", i), res, vecs[i].expResult);
            checkOutput($sformatf("vec%0d_zero", i), {31'b0, z}, {31'b0, vecs[i].expZero});
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
            checkOutput($sformatf("vec%0d_busy_ready", i), 32'(busy), 32'd0);
        end
        step();

        // Backpressure, then drain and accept on the same edge.
        out_ready = 1'b0;
        applyStimulus(ALU_ADD, 32'd3, 32'd4, res, z, lat, busy);
        checkOutput("bp_result", res, 32'd7);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("bp_hold%0d_result", i), result, 32'd7);
            checkOutput($sformatf("bp_hold%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
            checkOutput($sformatf("bp_hold%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
        end
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        alu_control = ALU_XOR;
        op_a        = 32'hF0;
        op_b        = 32'hFF;
        #1;
        checkOutput("drain_accept_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        checkOutput("drain_accept_out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("drain_accept_result", result, 32'h0F);
        checkOutput("drain_accept_zero", {31'b0, zero}, 32'd0);

        // Streaming single-cycle ops with out_ready high.
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            in_valid    = 1'b1;
            alu_control = ALU_ADD;
            op_a        = a;
            op_b        = b;
            expQ.push_back(refModel(ALU_ADD, a, b));
            step();
            checkOutput($sformatf("stream%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
            expd = expQ.pop_front();
            checkOutput($sformatf("stream%0d_result", i), result, expd);
        end
        in_valid = 1'b0;
        step();

        // Random ops against the reference model, with occasional backpressure.
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
            applyStimulus(op, a, b, res, z, lat, busy);
            expd = refModel(op, a, b);
            checkOutput($sformatf("rand%0d_op%0d_result", i, op), res, expd);
            checkOutput($sformatf("rand%0d_zero", i), {31'b0, z}, {31'b0, (expd == 32'h0)});
            checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'(refLat(op, b)));
            checkOutput($sformatf("rand%0d_busy_ready", i), 32'(busy), 32'd0);
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    step();
                    checkOutput($sformatf("rand%0d_hold_result", i), result, expd);
                    checkOutput($sformatf("rand%0d_hold_valid", i), {31'b0, out_valid}, 32'd1);
                end
                out_ready = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
